tinypong_btn_conditioner: RTL
=============================

Name: tinypong_btn_conditioner

Overview:
Input-conditioning stage directly upstream of the pong game core. It takes the raw, asynchronous, bouncing up/down pushbutton pins and produces clean levels for the paddle logic. It also produces one-cycle press pulses and per-frame sticky move requests, so that a short tap between two frame updates still moves the paddle. It resolves up+down conflicts before they reach the game.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a level change (10 ms at 25 MHz); must be >= 2
CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  25 MHz pixel/system clock, the only clock
rst  input  1  synchronous reset, active-high
btn_up_raw  input  1  asynchronous up button pin, active-high
btn_down_raw  input  1  asynchronous down button pin, active-high
frame_tick  input  1  one-cycle pulse at the game's per-frame update point (h=0, v=0)
btn_up  output  1  debounced, conflict-resolved up level
btn_down  output  1  debounced, conflict-resolved down level
up_press  output  1  one-cycle pulse on accepted up press
down_press  output  1  one-cycle pulse on accepted down press
up_move  output  1  up request for the current frame (level or sticky)
down_move  output  1  down request for the current frame (level or sticky)
conflict  output  1  both buttons stably pressed

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high.
- Reset: all outputs are 0. Synchronizer flops, stable states, counters and sticky flags clear to 0.
- Synchronizer, per channel: two flops, sync1 <= raw and sync2 <= sync1. No logic between the two flops.
- Debounce, one independent instance per channel:
  - Registers: stable (1 bit) and cnt (CNT_W bits).
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A single cycle of agreement with stable restarts the count (glitch rejection).
- Debounce state naming, for coverage: IDLE (stable=0, cnt=0), ARM_PRESS (stable=0, cnt>0), HELD (stable=1, cnt=0), ARM_RELEASE (stable=1, cnt>0).
- Latency: a raw edge that is clean and held is accepted DEBOUNCE_CYCLES+2 cycles after the first clock edge that samples it. stable rises on that edge.
- Press pulse: up_press = stable_up rose this cycle AND stable_down == 0. It is registered, so it is high for exactly the one cycle following the stable transition. Release produces no pulse.
- Conflict:
  - conflict = stable_up & stable_down, registered.
  - While conflict is high, btn_up and btn_down are both 0 and no press pulses are emitted.
  - A press of the second button while the first is held produces no pulse for either button.
  - When one button releases, the other button's level reappears on btn_* with no pulse.
- Levels: btn_up = stable_up & ~stable_down, registered. btn_down is symmetric.
- Sticky flags (seen_up, seen_down):
  - Set on the corresponding press pulse.
  - Cleared on frame_tick.
  - If frame_tick and a press pulse occur in the same cycle, set wins (the flag stays 1 for the next frame).
- Frame requests:
  - up_move = btn_up | seen_up.
  - down_move = btn_down | seen_down.
  - If both would be 1, both are forced to 0 for that cycle.
- Reset mid-debounce discards the in-flight count. After reset, a held button is re-accepted after a full DEBOUNCE_CYCLES+2 cycles.
- Counter never wraps: it is bounded by DEBOUNCE_CYCLES-1 < 2^CNT_W.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and CNT_W=3.
1. Clean press: rst for 2 cycles, then btn_up_raw=1 held. Require btn_up=1 and up_press=1 for exactly 1 cycle, both appearing 7 cycles after the raise (2 sync + 4 debounce + 1 output register). up_move=1 while held.
2. Bounce rejection: btn_up_raw toggles 1,1,1,0,1,1,1,0 repeatedly. Require btn_up=0 throughout and counter never above 3. After the signal is held at 1, btn_up rises exactly 7 cycles after the last 0→1 edge.
3. Short tap across frame: an up press is accepted and released 20 cycles later, with no frame_tick in between. Require up_move to stay 1 after release until the first frame_tick, and to be 0 the cycle after it. Repeat with frame_tick coincident with up_press: require up_move still 1 after that tick, cleared at the next tick.
4. Conflict: hold up (accepted), then press down. Require conflict=1, btn_up=btn_down=0, no down_press, up_move=down_move=0. Release up: require btn_down=1 with no down_press pulse.
5. Reset mid-operation: assert rst while in ARM_PRESS with cnt=2. Require all outputs to be 0 the next cycle. After rst deasserts with raw still high, btn_up reasserts after 7 cycles.
6. Release: from HELD, btn_up_raw=0. Require btn_up to fall 7 cycles later, no pulse, and seen_up unaffected.

Source files
------------

// File: rtl/tinypong_btn_conditioner.sv
// Pushbutton front end for the pong core: synchronize, debounce,
// resolve up/down conflicts, and latch taps until the next frame.
module tinypong_btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic frame_tick,
    output logic btn_up,
    output logic btn_down,
    output logic up_press,
    output logic down_press,
    output logic up_move,
    output logic down_move,
    output logic conflict
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel index 0 is up, 1 is down.
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       stable;
    logic [1:0]       stable_q;
    logic [1:0]       rise;
    logic [CNT_W-1:0] cnt [2];
    logic             seen_up;
    logic             seen_down;
    logic             want_up;
    logic             want_down;

    assign raw = {btn_down_raw, btn_up_raw};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Any cycle that agrees with the accepted level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = stable & ~stable_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q   <= '0;
            btn_up     <= 1'b0;
            btn_down   <= 1'b0;
            conflict   <= 1'b0;
            up_press   <= 1'b0;
            down_press <= 1'b0;
            seen_up    <= 1'b0;
            seen_down  <= 1'b0;
        end else begin
            stable_q   <= stable;
            btn_up     <= stable[0] & ~stable[1];
            btn_down   <= stable[1] & ~stable[0];
            conflict   <= stable[0] & stable[1];
            up_press   <= rise[0] & ~stable[1];
            down_press <= rise[1] & ~stable[0];
            // A press in the tick cycle survives into the next frame.
            seen_up    <= up_press | (seen_up & ~frame_tick);
            seen_down  <= down_press | (seen_down & ~frame_tick);
        end
    end

    assign want_up   = btn_up | seen_up;
    assign want_down = btn_down | seen_down;
    assign up_move   = want_up & ~want_down;
    assign down_move = want_down & ~want_up;

endmodule
